// File: rtl/mult_ctrl.sv
// mult_ctrl -- sequencer for a shift/add multiplier.
//
// Drives an external accumulator that holds {upper, multiplier}. Each multiply
// loads the accumulator, then runs WIDTH iterations. An iteration tests the
// current multiplier bit, optionally adds, then shifts right. The product sits
// on the accumulator while done is high.
//
// Ports:
//   clock  - rising-edge system clock
//   rst    - asynchronous, active-high reset
//   start  - begin one multiply (only looked at in IDLE)
//   lsb    - bit 0 of the accumulator (current multiplier bit, only looked at in TEST)
//   load   - accumulator load strobe
//   ad     - accumulator add strobe
//   shift  - accumulator logical-right-shift strobe
//   busy   - high from LOAD through the final SHIFT
//   done   - one-cycle pulse, product valid
module mult_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic clock,
    input  logic rst,
    input  logic start,
    input  logic lsb,
    output logic load,
    output logic ad,
    output logic shift,
    output logic busy,
    output logic done
);

    // One extra bit so that counting to WIDTH-1 never wraps, even when WIDTH
    // is a power of two.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t         state;
    logic [CW-1:0]  count;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE:  if (start) state <= LOAD;
                LOAD: begin
                    count <= '0;
                    state <= TEST;
                end
                TEST:  state <= lsb ? ADD : SHIFT;
                ADD:   state <= SHIFT;
                SHIFT: begin
                    if (count == LAST) begin
                        state <= DONE;
                    end else begin
                        count <= count + CW'(1);
                        state <= TEST;
                    end
                end
                DONE:  state <= IDLE;
                // Encodings 6 and 7 recover to IDLE.
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decode: strobes depend only on the state register, so they are
    // mutually exclusive by construction and drop as soon as rst forces IDLE.
    assign load  = (state == LOAD);
    assign ad    = (state == ADD);
    assign shift = (state == SHIFT);
    assign busy  = (state == LOAD) || (state == TEST) || (state == ADD) || (state == SHIFT);
    assign done  = (state == DONE);

endmodule
